// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and its future receiver.
// State encodings and idle/start/stop line levels live here.
package serial_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam logic SD_IDLE  = 1'b1;
    localparam logic SD_START = 1'b0;
    localparam logic SD_STOP  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Per-bit cycle counter for the serial frame transmitter.
// bit_tick marks the last cycle of a bit; last_next predicts it one cycle early.
module bit_timer #(
    parameter int BIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick,
    output logic last_next
);

    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        bit_tick = (cnt_q == LAST);
        cnt_d    = cnt_q + CW'(1);
        if (clr || bit_tick) begin
            cnt_d = '0;
        end
        last_next = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framed transmitter: start bit, data MSB first, stop bit.
// Outputs are registered from the next-state values so sd changes only on clk.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sd,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("serial_frame_tx: WIDTH must be >= 1");
    end
    if (BIT_CYCLES < 1) begin : g_bad_cycles
        $error("serial_frame_tx: BIT_CYCLES must be >= 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             sd_q, sd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_tick;
    logic             last_next;
    logic             accept;

    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign sd       = sd_q;
    assign busy     = busy_q;
    assign done     = done_q;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == ST_IDLE),
        .bit_tick (bit_tick),
        .last_next(last_next)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q << 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is derived from where the FSM will be next cycle.
        case (state_d)
            ST_START: sd_d = SD_START;
            ST_DATA:  sd_d = shift_d[WIDTH-1];
            ST_STOP:  sd_d = SD_STOP;
            default:  sd_d = SD_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && last_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            sd_q    <= SD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            sd_q    <= sd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: 8-bit/2-cycle and 4-bit/1-cycle builds.
// Per-cycle outputs are shifted into vectors and compared against hand values.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a;
    logic [7:0] in_data_a;
    logic       in_valid_a;
    logic       in_ready_a;
    logic       sd_a;
    logic       busy_a;
    logic       done_a;

    logic       rst_b;
    logic [3:0] in_data_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic       sd_b;
    logic       busy_b;
    logic       done_b;

    serial_frame_tx #(
        .WIDTH(8),
        .BIT_CYCLES(2)
    ) u_dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .in_data (in_data_a),
        .in_valid(in_valid_a),
        .in_ready(in_ready_a),
        .sd      (sd_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    serial_frame_tx #(
        .WIDTH(4),
        .BIT_CYCLES(1)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .in_data (in_data_b),
        .in_valid(in_valid_b),
        .in_ready(in_ready_b),
        .sd      (sd_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    int checks = 0;
    int errors = 0;
    int acc_a  = 0;

    logic [63:0] sdv, donev, busyv, rdyv;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_v();
        sdv   = '0;
        donev = '0;
        busyv = '0;
        rdyv  = '0;
    endtask

    task automatic step_a(input int n);
        for (int i = 0; i < n; i++) begin
            if (in_valid_a && in_ready_a) acc_a++;
            @(posedge clk);
            #1;
            sdv   = {sdv[62:0], sd_a};
            donev = {donev[62:0], done_a};
            busyv = {busyv[62:0], busy_a};
            rdyv  = {rdyv[62:0], in_ready_a};
        end
    endtask

    task automatic step_b(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sdv   = {sdv[62:0], sd_b};
            donev = {donev[62:0], done_b};
            busyv = {busyv[62:0], busy_b};
            rdyv  = {rdyv[62:0], in_ready_b};
        end
    endtask

    task automatic frame_a(input logic [7:0] w, input logic [7:0] alt,
                           input logic [19:0] exp_sd, input string tag);
        check({tag, "_rdy0"}, 64'(in_ready_a), 64'd1);
        in_data_a  = w;
        in_valid_a = 1'b1;
        clr_v();
        step_a(1);
        in_valid_a = 1'b0;
        in_data_a  = alt;
        step_a(19);
        check({tag, "_sd"}, 64'(sdv[19:0]), 64'(exp_sd));
        check({tag, "_done"}, 64'(donev[19:0]), 64'h00001);
        check({tag, "_busy"}, 64'(busyv[19:0]), 64'hFFFFF);
        check({tag, "_rdy"}, 64'(rdyv[19:0]), 64'h0);
        step_a(1);
        check({tag, "_idle"}, 64'({sd_a, busy_a, in_ready_a, done_a}),
              64'b1010);
    endtask

    initial begin
        rst_a      = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = 8'h55;
        rst_b      = 1'b1;
        in_valid_b = 1'b0;
        in_data_b  = 4'h0;

        clr_v();
        step_a(3);
        check("rst_sd", 64'(sdv[2:0]), 64'b111);
        check("rst_busy", 64'(busyv[2:0]), 64'b000);
        check("rst_done", 64'(donev[2:0]), 64'b000);
        check("rst_rdy", 64'(rdyv[2:0]), 64'b000);

        rst_a      = 1'b0;
        rst_b      = 1'b0;
        in_valid_a = 1'b0;
        clr_v();
        step_a(2);
        check("rel_sd", 64'(sdv[1:0]), 64'b11);
        check("rel_busy", 64'(busyv[1:0]), 64'b00);

        frame_a(8'hA5, 8'hA5, 20'h330CF, "a5");

        // back-to-back: valid held high across two frames
        acc_a      = 0;
        in_data_a  = 8'hFF;
        in_valid_a = 1'b1;
        clr_v();
        step_a(1);
        in_data_a = 8'h00;
        step_a(19);
        check("b2b_sd1", 64'(sdv[19:0]), 64'h3FFFF);
        check("b2b_done1", 64'(donev[19:0]), 64'h00001);
        step_a(1);
        check("b2b_gap", 64'({sd_a, busy_a, in_ready_a}), 64'b101);
        clr_v();
        step_a(1);
        in_valid_a = 1'b0;
        step_a(19);
        check("b2b_sd2", 64'(sdv[19:0]), 64'h00003);
        check("b2b_done2", 64'(donev[19:0]), 64'h00001);
        check("b2b_acc", 64'(acc_a), 64'd2);
        step_a(1);

        // reset in the middle of an A5 frame
        in_data_a  = 8'hA5;
        in_valid_a = 1'b1;
        clr_v();
        step_a(1);
        in_valid_a = 1'b0;
        step_a(8);
        check("mid_c9", 64'({sd_a, busy_a}), 64'b01);
        rst_a = 1'b1;
        step_a(1);
        check("mid_c10", 64'({sd_a, busy_a, done_a, in_ready_a}),
              64'b1000);
        rst_a = 1'b0;
        clr_v();
        step_a(15);
        check("mid_nodone", 64'(donev[14:0]), 64'h0);
        check("mid_nobusy", 64'(busyv[14:0]), 64'h0);
        check("mid_sd", 64'(sdv[14:0]), 64'h7FFF);

        frame_a(8'hA5, 8'hA5, 20'h330CF, "a5_post");
        frame_a(8'h3C, 8'hC3, 20'h03FC3, "hold3c");

        // 4-bit word at one clock per bit
        check("b_rdy0", 64'(in_ready_b), 64'd1);
        in_data_b  = 4'b1001;
        in_valid_b = 1'b1;
        clr_v();
        step_b(1);
        in_valid_b = 1'b0;
        in_data_b  = 4'b0110;
        step_b(5);
        check("b_sd", 64'(sdv[5:0]), 64'b010011);
        check("b_done", 64'(donev[5:0]), 64'b000001);
        check("b_busy", 64'(busyv[5:0]), 64'b111111);
        check("b_rdy", 64'(rdyv[5:0]), 64'b000000);
        step_b(1);
        check("b_c7", 64'({in_ready_b, sd_b, busy_b, done_b}), 64'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
